// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// One transaction in flight; data side has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                If_Req,
    input  logic [ADDR_W-1:0]   If_Addr,
    input  logic                Flush_F,
    output logic                If_Ack,
    output logic [DATA_W-1:0]   If_RData,
    input  logic                Dm_Req,
    input  logic                Dm_We,
    input  logic [ADDR_W-1:0]   Dm_Addr,
    input  logic [DATA_W-1:0]   Dm_WData,
    input  logic [DATA_W/8-1:0] Dm_WMask,
    output logic                Dm_Ack,
    output logic [DATA_W-1:0]   Dm_RData,
    output logic                Err,
    output logic                Mem_Valid,
    output logic                Mem_We,
    output logic [ADDR_W-1:0]   Mem_Addr,
    output logic [DATA_W-1:0]   Mem_WData,
    output logic [DATA_W/8-1:0] Mem_WMask,
    input  logic                Mem_Ready,
    input  logic                Mem_Done,
    input  logic [DATA_W-1:0]   Mem_RData,
    output logic                Stall_F,
    output logic                Stall_M
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TMO_W    = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arbStateT;

    arbStateT              state;
    arbStateT              nextState;
    logic                  ownerDm;
    logic                  fetchCancel;
    logic [STARVE_W-1:0]   starveCnt;
    logic [TMO_W-1:0]      tmoCnt;

    logic                  grantDm;
    logic                  grantIf;
    logic                  memAccept;
    logic                  doneNow;
    logic                  timedOut;
    logic                  starveHit;
    logic                  tmoHit;

    function automatic logic [STARVE_W-1:0] satInc(input logic [STARVE_W-1:0] v);
        return (v == STARVE_W'(STARVE_MAX)) ? v : v + 1'b1;
    endfunction

    assign starveHit = (starveCnt == STARVE_W'(STARVE_MAX));
    assign tmoHit    = (tmoCnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        grantDm   = 1'b0;
        grantIf   = 1'b0;
        memAccept = 1'b0;
        doneNow   = 1'b0;
        timedOut  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Dm_Req && !(If_Req && starveHit)) begin
                    grantDm = 1'b1;
                end else if (If_Req && !Flush_F) begin
                    grantIf = 1'b1;
                end
                if (grantDm || grantIf) begin
                    nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                memAccept = Mem_Ready;
                doneNow   = Mem_Ready && Mem_Done;
                if (doneNow) begin
                    nextState = S_RESP;
                end else if (tmoHit) begin
                    timedOut  = 1'b1;
                    nextState = S_RESP;
                end else if (Mem_Ready) begin
                    nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                doneNow = Mem_Done;
                if (doneNow) begin
                    nextState = S_RESP;
                end else if (tmoHit) begin
                    timedOut  = 1'b1;
                    nextState = S_RESP;
                end
            end
            S_RESP: begin
                nextState = S_IDLE;
            end
            default: begin
                nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ownerDm     <= 1'b0;
            fetchCancel <= 1'b0;
            starveCnt   <= '0;
            tmoCnt      <= '0;
            Mem_Valid   <= 1'b0;
            Mem_We      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_WData   <= '0;
            Mem_WMask   <= '0;
            If_Ack      <= 1'b0;
            Dm_Ack      <= 1'b0;
            Err         <= 1'b0;
            If_RData    <= '0;
            Dm_RData    <= '0;
        end else begin
            If_Ack <= 1'b0;
            Dm_Ack <= 1'b0;
            Err    <= 1'b0;

            // arbitration: starvation only accrues while a fetch is actually waiting
            if (state == S_IDLE) begin
                if (grantDm && If_Req) begin
                    starveCnt <= satInc(starveCnt);
                end else if (grantIf || !If_Req) begin
                    starveCnt <= '0;
                end
            end

            if (grantDm || grantIf) begin
                ownerDm     <= grantDm;
                fetchCancel <= 1'b0;
                tmoCnt      <= '0;
                Mem_Valid   <= 1'b1;
                Mem_We      <= grantDm && Dm_We;
                Mem_Addr    <= grantDm ? Dm_Addr : If_Addr;
                Mem_WData   <= grantDm ? Dm_WData : '0;
                Mem_WMask   <= grantDm ? Dm_WMask : MASK_W'(0);
            end

            // memory phase: the fetch still completes on the bus after a flush, only its ack is dropped
            if (state == S_ISSUE || state == S_WAIT) begin
                tmoCnt <= tmoCnt + 1'b1;
                if (!ownerDm && Flush_F) begin
                    fetchCancel <= 1'b1;
                end
            end

            if (memAccept || timedOut) begin
                Mem_Valid <= 1'b0;
            end

            // response: ack and data registered so they appear together in RESP
            if (doneNow || timedOut) begin
                if (ownerDm) begin
                    Dm_RData <= timedOut ? '0 : Mem_RData;
                    Dm_Ack   <= 1'b1;
                    Err      <= timedOut;
                end else begin
                    If_RData <= timedOut ? '0 : Mem_RData;
                    if (!(fetchCancel || Flush_F)) begin
                        If_Ack <= 1'b1;
                        Err    <= timedOut;
                    end
                end
            end
        end
    end

    assign Stall_F = If_Req && !If_Ack && !Flush_F;
    assign Stall_M = Dm_Req && !Dm_Ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory responder, grant-order and ack queues.
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Reset;
    logic        If_Req;
    logic [31:0] If_Addr;
    logic        Flush_F;
    logic        If_Ack;
    logic [31:0] If_RData;
    logic        Dm_Req;
    logic        Dm_We;
    logic [31:0] Dm_Addr;
    logic [31:0] Dm_WData;
    logic [3:0]  Dm_WMask;
    logic        Dm_Ack;
    logic [31:0] Dm_RData;
    logic        Err;
    logic        Mem_Valid;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_WMask;
    logic        Mem_Ready;
    logic        Mem_Done;
    logic [31:0] Mem_RData;
    logic        Stall_F;
    logic        Stall_M;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .If_Req(If_Req), .If_Addr(If_Addr), .Flush_F(Flush_F),
        .If_Ack(If_Ack), .If_RData(If_RData),
        .Dm_Req(Dm_Req), .Dm_We(Dm_We), .Dm_Addr(Dm_Addr),
        .Dm_WData(Dm_WData), .Dm_WMask(Dm_WMask),
        .Dm_Ack(Dm_Ack), .Dm_RData(Dm_RData), .Err(Err),
        .Mem_Valid(Mem_Valid), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_WMask(Mem_WMask),
        .Mem_Ready(Mem_Ready), .Mem_Done(Mem_Done), .Mem_RData(Mem_RData),
        .Stall_F(Stall_F), .Stall_M(Stall_M)
    );

    typedef struct {
        bit          isDm;
        bit          err;
        bit          chkData;
        logic [31:0] data;
        int          lat;
    } expT;

    expT         expQ[$];
    logic [31:0] gntQ[$];
    logic [31:0] memArr[logic [31:0]];

    int checks = 0;
    int errors = 0;

    // responder knobs, written only by the main stimulus process
    int readyDelay = 0;
    int doneDelay  = 0;
    bit noDone     = 0;
    int injReq     = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memRd(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // memory responder: Ready after readyDelay wait cycles, Done doneDelay cycles after accept
    initial begin : responder
        int          wcnt;
        int          dcnt;
        int          injSeen;
        bit          pending;
        bit          prevV;
        logic [31:0] pAddr;
        logic [31:0] old;
        wcnt = 0; dcnt = 0; injSeen = 0; pending = 0; prevV = 0; pAddr = '0;
        Mem_Ready = 1'b0; Mem_Done = 1'b0; Mem_RData = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (Mem_Ready && !Mem_Done) begin
                pending = 1;
                dcnt = 0;
            end else if (Mem_Done) begin
                pending = 0;
            end
            if (Mem_Valid && !prevV) begin
                pending = 0;
                wcnt = 0;
            end
            if (!Reset) pending = 0;
            prevV = Mem_Valid;
            Mem_Ready = 1'b0;
            Mem_Done  = 1'b0;
            Mem_RData = '0;
            if (injReq != injSeen) begin
                injSeen   = injReq;
                Mem_Done  = 1'b1;
                Mem_RData = 32'hBAD0BAD0;
            end else if (pending) begin
                dcnt++;
                if (!noDone && dcnt >= doneDelay) begin
                    Mem_Done  = 1'b1;
                    Mem_RData = memRd(pAddr);
                end
            end else if (Mem_Valid) begin
                wcnt++;
                if (wcnt > readyDelay) begin
                    Mem_Ready = 1'b1;
                    pAddr = Mem_Addr;
                    if (Mem_We) begin
                        old = memRd(Mem_Addr);
                        for (int b = 0; b < 4; b++)
                            if (Mem_WMask[b]) old[b*8 +: 8] = Mem_WData[b*8 +: 8];
                        memArr[Mem_Addr] = old;
                    end
                    if (!noDone && doneDelay == 0) begin
                        Mem_Done  = 1'b1;
                        Mem_RData = memRd(Mem_Addr);
                    end
                end
            end
        end
    end

    // monitor: grant addresses and acks popped against the scoreboard queues
    initial begin : monitor
        int          cyc;
        int          riseCyc;
        bit          prevValid;
        logic [31:0] a;
        expT         e;
        cyc = 0; riseCyc = 0; prevValid = 0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (Mem_Valid && !prevValid) begin
                riseCyc = cyc;
                if (gntQ.size() > 0) begin
                    a = gntQ.pop_front();
                    chk("gntAddr", Mem_Addr, a);
                end else begin
                    chk("unexpGrant", 1, 0);
                end
            end
            prevValid = Mem_Valid;
            if (If_Ack || Dm_Ack) begin
                chk("dualAck", If_Ack && Dm_Ack, 0);
                if (expQ.size() == 0) begin
                    chk("unexpAck", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    chk("ackPort", Dm_Ack, e.isDm);
                    chk("ackErr", Err, e.err);
                    if (e.chkData) chk("ackRData", e.isDm ? Dm_RData : If_RData, e.data);
                    chk("ackLatency", cyc - riseCyc + 1, e.lat);
                end
            end
        end
    end

    task automatic xfer(input bit isDm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input bit expErr, input int lat);
        bit got;
        gntQ.push_back(addr);
        expQ.push_back('{isDm: isDm, err: expErr, chkData: !we,
                         data: expErr ? 32'h0 : memRd(addr), lat: lat});
        if (isDm) begin
            Dm_Req = 1; Dm_We = we; Dm_Addr = addr; Dm_WData = wdata; Dm_WMask = mask;
        end else begin
            If_Req = 1; If_Addr = addr;
        end
        #1;
        chk(isDm ? "stallMReq" : "stallFReq", isDm ? Stall_M : Stall_F, 1);
        tick();
        chk("gntValid", Mem_Valid, 1);
        chk("gntWe", Mem_We, isDm && we);
        chk("gntMask", Mem_WMask, (isDm && we) ? mask : 4'h0);
        got = 0;
        for (int i = 0; i < 80; i++) begin
            if (isDm ? Dm_Ack : If_Ack) begin
                got = 1;
                break;
            end
            tick();
        end
        if (!got) chk(isDm ? "dmAckWait" : "ifAckWait", 0, 1);
        tick();
        if (isDm) Dm_Req = 0; else If_Req = 0;
        #1;
        chk(isDm ? "stallMDrop" : "stallFDrop", isDm ? Stall_M : Stall_F, 0);
    endtask

    initial begin : stim
        int  n;
        int  vc;
        int  bad;
        int  ac;
        bit  dropNext;
        bit  seen;
        Reset = 0; If_Req = 0; If_Addr = '0; Flush_F = 0;
        Dm_Req = 0; Dm_We = 0; Dm_Addr = '0; Dm_WData = '0; Dm_WMask = '0;
        repeat (3) tick();
        chk("rstAcks", {If_Ack, Dm_Ack, Err}, 0);
        chk("rstMemValid", {Mem_Valid, Mem_We}, 0);
        chk("rstMemAddr", Mem_Addr, 0);
        chk("rstMemWData", {Mem_WData, Mem_WMask}, 0);
        chk("rstRData", {If_RData, Dm_RData}, 0);
        Reset = 1;
        tick();

        // T1 load, Done one cycle after accept
        memArr[32'h2000] = 32'hDEADBEEF;
        readyDelay = 0; doneDelay = 1;
        xfer(1, 0, 32'h2000, 0, 4'h0, 0, 3);
        // minimum latency load and fetch
        doneDelay = 0;
        xfer(1, 0, 32'h2004, 0, 4'h0, 0, 2);
        xfer(0, 0, 32'h1000, 0, 4'h0, 0, 2);

        // T3 store with Ready held off for three cycles
        memArr[32'h100] = 32'hAABBCCDD;
        readyDelay = 3; doneDelay = 1;
        gntQ.push_back(32'h100);
        expQ.push_back('{isDm: 1, err: 0, chkData: 0, data: 32'h0, lat: 6});
        Dm_Req = 1; Dm_We = 1; Dm_Addr = 32'h100; Dm_WData = 32'h12345678; Dm_WMask = 4'b0011;
        vc = 0; bad = 0; ac = 0; dropNext = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dropNext) begin
                Dm_Req = 0; Dm_We = 0;
                dropNext = 0;
            end
            if (Mem_Valid) begin
                vc++;
                if (Mem_Addr != 32'h100 || Mem_WData != 32'h12345678 ||
                    Mem_WMask != 4'b0011 || !Mem_We) bad++;
            end
            if (Dm_Ack) begin
                ac++;
                dropNext = 1;
            end
        end
        chk("t3ValidCycles", vc, 4);
        chk("t3MemStable", bad, 0);
        chk("t3AckCount", ac, 1);
        chk("t3MemWrite", memArr[32'h100], 32'hAABB5678);

        // T2 both requesters held high: DM x4, IF, DM x4, IF
        readyDelay = 0; doneDelay = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                gntQ.push_back(32'h2100);
                expQ.push_back('{isDm: 1, err: 0, chkData: 1, data: memRd(32'h2100), lat: 2});
            end
            gntQ.push_back(32'h1100);
            expQ.push_back('{isDm: 0, err: 0, chkData: 1, data: memRd(32'h1100), lat: 2});
        end
        If_Req = 1; If_Addr = 32'h1100;
        Dm_Req = 1; Dm_We = 0; Dm_Addr = 32'h2100;
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            tick();
            if (If_Ack || Dm_Ack) n++;
        end
        chk("t2AckTotal", n, 10);
        tick();
        If_Req = 0; Dm_Req = 0;
        tick();

        // T4 fetch flushed during WAIT, refetch from the redirected address
        readyDelay = 0; doneDelay = 3;
        gntQ.push_back(32'h1040);
        gntQ.push_back(32'h1080);
        expQ.push_back('{isDm: 0, err: 0, chkData: 1, data: memRd(32'h1080), lat: 5});
        If_Req = 1; If_Addr = 32'h1040;
        #1;
        chk("t4StallF", Stall_F, 1);
        tick();
        chk("t4IfWe", {Mem_We, Mem_WMask}, 0);
        tick();
        Flush_F = 1; If_Addr = 32'h1080;
        #1;
        chk("t4StallFlush", Stall_F, 0);
        tick();
        Flush_F = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (If_Ack) begin
                seen = 1;
                break;
            end
        end
        chk("t4RefetchAck", seen, 1);
        tick();
        If_Req = 0;
        tick();

        // T5 timeouts: Done never arrives, then Ready never arrives
        noDone = 1; readyDelay = 0;
        xfer(1, 0, 32'h2040, 0, 4'h0, 1, 17);
        readyDelay = 100;
        xfer(0, 0, 32'h1200, 0, 4'h0, 1, 17);
        chk("t5ValidDropped", Mem_Valid, 0);
        noDone = 0; readyDelay = 0; doneDelay = 1;
        xfer(1, 0, 32'h2000, 0, 4'h0, 0, 3);

        // T6 reset during WAIT, late Done afterwards must be ignored
        noDone = 1; readyDelay = 0;
        gntQ.push_back(32'h2080);
        Dm_Req = 1; Dm_We = 0; Dm_Addr = 32'h2080;
        repeat (3) tick();
        Reset = 0;
        tick();
        chk("t6RstValid", Mem_Valid, 0);
        chk("t6RstAddr", Mem_Addr, 0);
        chk("t6StallHi", Stall_M, 1);
        Dm_Req = 0;
        #1;
        chk("t6StallLo", Stall_M, 0);
        Reset = 1;
        injReq++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (If_Ack || Dm_Ack || Err || Mem_Valid) seen = 1;
        end
        chk("t6NoActivity", seen, 0);
        chk("t6RData", {If_RData, Dm_RData}, 0);
        noDone = 0;

        chk("expQLeft", expQ.size(), 0);
        chk("gntQLeft", gntQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
